// File: rtl/policy_scheduler_pkg.sv
// rtl/policy_scheduler_pkg.sv - shared widths, constants and FSM encoding for policy_scheduler
package policy_scheduler_pkg;
    localparam int WORD_W = 16;
    localparam int WDOG_W = 6;
    localparam logic [WORD_W-1:0] NEXTHOP_NONE = 16'd100;
    localparam logic [WDOG_W-1:0] WATCHDOG_LIMIT = 6'd63;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LAUNCH = 3'd1,
        ST_WAIT   = 3'd2,
        ST_DECAY  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    // Unsigned decrement that floors at zero instead of wrapping.
    function automatic logic [WORD_W-1:0] sat_sub(input logic [WORD_W-1:0] a,
                                                 input logic [WORD_W-1:0] b);
        return (a < b) ? '0 : a - b;
    endfunction
endpackage

// File: rtl/mem_rr_arbiter.sv
// rtl/mem_rr_arbiter.sv - two-requester round-robin memory read arbiter with registered grant
module mem_rr_arbiter
    import policy_scheduler_pkg::*;
(
    input  logic              clock,
    input  logic              nrst,
    input  logic              req_a,
    input  logic              req_b,
    input  logic [WORD_W-1:0] addr_a,
    input  logic [WORD_W-1:0] addr_b,
    output logic              grant_a,
    output logic              grant_b,
    output logic [WORD_W-1:0] mem_addr
);
    // Priority only moves on contention, so a lone requester never steals the next turn.
    logic prio_b;

    always_ff @(posedge clock) begin
        if (!nrst) begin
            grant_a  <= 1'b0;
            grant_b  <= 1'b0;
            mem_addr <= '0;
            prio_b   <= 1'b0;
        end else begin
            grant_a <= 1'b0;
            grant_b <= 1'b0;
            if (req_a && (!req_b || !prio_b)) begin
                grant_a  <= 1'b1;
                mem_addr <= addr_a;
            end else if (req_b) begin
                grant_b  <= 1'b1;
                mem_addr <= addr_b;
            end
            if (req_a && req_b) begin
                prio_b <= !prio_b;
            end
        end
    end
endmodule

// File: rtl/policy_scheduler.sv
// rtl/policy_scheduler.sv - batch round scheduler for the policy engine with epsilon decay and watchdog
module policy_scheduler
    import policy_scheduler_pkg::*;
(
    input  logic              clock,
    input  logic              nrst,
    input  logic              start_round,
    input  logic [WORD_W-1:0] round_limit,
    input  logic [WORD_W-1:0] epsilon_init,
    input  logic [WORD_W-1:0] epsilon_step,
    input  logic              done_policy,
    input  logic [WORD_W-1:0] nexthop_in,
    input  logic              req_a,
    input  logic              req_b,
    input  logic [WORD_W-1:0] addr_a,
    input  logic [WORD_W-1:0] addr_b,
    output logic              start_policy,
    output logic [WORD_W-1:0] epsilon,
    output logic [WORD_W-1:0] nexthop,
    output logic [WORD_W-1:0] round_count,
    output logic              busy,
    output logic              round_done,
    output logic              timeout_flag,
    output logic [WORD_W-1:0] mem_addr,
    output logic              grant_a,
    output logic              grant_b
);
    state_t            state;
    logic [WDOG_W-1:0] watchdog;
    logic [WORD_W-1:0] limit_q;

    // start_policy and round_done are raised on entry so they coincide with LAUNCH and DONE.
    always_ff @(posedge clock) begin
        if (!nrst) begin
            state        <= ST_IDLE;
            start_policy <= 1'b0;
            busy         <= 1'b0;
            round_done   <= 1'b0;
            timeout_flag <= 1'b0;
            nexthop      <= NEXTHOP_NONE;
            round_count  <= '0;
            epsilon      <= epsilon_init;
            watchdog     <= '0;
            limit_q      <= '0;
        end else begin
            start_policy <= 1'b0;
            round_done   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start_round) begin
                        round_count <= '0;
                        limit_q     <= round_limit;
                        if (round_limit != '0) begin
                            busy         <= 1'b1;
                            start_policy <= 1'b1;
                            state        <= ST_LAUNCH;
                        end else begin
                            round_done <= 1'b1;
                            state      <= ST_DONE;
                        end
                    end
                end
                ST_LAUNCH: begin
                    watchdog <= '0;
                    state    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (done_policy) begin
                        nexthop <= nexthop_in;
                        state   <= ST_DECAY;
                    end else if (watchdog == WATCHDOG_LIMIT) begin
                        nexthop      <= NEXTHOP_NONE;
                        timeout_flag <= 1'b1;
                        state        <= ST_DECAY;
                    end else begin
                        watchdog <= watchdog + 1'b1;
                    end
                end
                ST_DECAY: begin
                    epsilon     <= sat_sub(epsilon, epsilon_step);
                    round_count <= round_count + 1'b1;
                    if (round_count + 1'b1 == limit_q) begin
                        round_done <= 1'b1;
                        state      <= ST_DONE;
                    end else begin
                        start_policy <= 1'b1;
                        state        <= ST_LAUNCH;
                    end
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    mem_rr_arbiter u_arb (
        .clock    (clock),
        .nrst     (nrst),
        .req_a    (req_a),
        .req_b    (req_b),
        .addr_a   (addr_a),
        .addr_b   (addr_b),
        .grant_a  (grant_a),
        .grant_b  (grant_b),
        .mem_addr (mem_addr)
    );
endmodule

// File: tb/tb_policy_scheduler.sv
// tb/tb_policy_scheduler.sv - self-checking bench for policy_scheduler
module tb_policy_scheduler;
    logic        clock, nrst, start_round, done_policy, req_a, req_b;
    logic [15:0] round_limit, epsilon_init, epsilon_step, nexthop_in, addr_a, addr_b;
    logic        start_policy, busy, round_done, timeout_flag, grant_a, grant_b;
    logic [15:0] epsilon, nexthop, round_count, mem_addr;

    policy_scheduler dut (
        .clock(clock), .nrst(nrst), .start_round(start_round), .round_limit(round_limit),
        .epsilon_init(epsilon_init), .epsilon_step(epsilon_step), .done_policy(done_policy),
        .nexthop_in(nexthop_in), .req_a(req_a), .req_b(req_b), .addr_a(addr_a), .addr_b(addr_b),
        .start_policy(start_policy), .epsilon(epsilon), .nexthop(nexthop),
        .round_count(round_count), .busy(busy), .round_done(round_done),
        .timeout_flag(timeout_flag), .mem_addr(mem_addr), .grant_a(grant_a), .grant_b(grant_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_pass = 0;
    int n_total = 0;
    int t = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, t);
    endtask

    // Model: event times of the batch expressed as absolute cycle numbers.
    bit m_valid = 0;
    bit in_wait, m_ptr_b;
    int m_busy, m_rounds, m_limit, m_eps, m_nh, m_to;
    int launch_t, decay_t, done_t;
    int m_ga, m_gb, m_addr;
    int sp_count = 0, rd_count = 0, rd_t = -1;
    int eps_log[$];

    task automatic model_step();
        int  n;
        bit  idle;
        n = t + 1;
        if (!nrst) begin
            m_valid = 1; in_wait = 0; m_ptr_b = 0;
            m_busy = 0; m_rounds = 0; m_limit = 0; m_eps = int'(epsilon_init);
            m_nh = 100; m_to = 0; launch_t = -1; decay_t = -1; done_t = -1;
            m_ga = 0; m_gb = 0; m_addr = 0;
        end else begin
            idle = (m_busy == 0) && (done_t < 0);
            if (t == done_t) begin
                m_busy = 0;
                done_t = -1;
            end
            if (idle && start_round) begin
                m_rounds = 0;
                if (round_limit == 0) done_t = n;
                else begin
                    m_busy = 1; m_limit = int'(round_limit); launch_t = n;
                end
            end
            if (in_wait) begin
                if (done_policy) begin
                    m_nh = int'(nexthop_in); in_wait = 0; decay_t = n;
                end else if (t - launch_t == 64) begin
                    m_nh = 100; m_to = 1; in_wait = 0; decay_t = n;
                end
            end else if (t == launch_t) begin
                in_wait = 1;
            end
            if (t == decay_t) begin
                m_eps = (m_eps < int'(epsilon_step)) ? 0 : m_eps - int'(epsilon_step);
                m_rounds++;
                if (m_rounds == m_limit) done_t = n;
                else launch_t = n;
                decay_t = -1;
            end
            m_ga = 0; m_gb = 0;
            if (req_a && req_b) begin
                if (m_ptr_b) begin m_gb = 1; m_addr = int'(addr_b); end
                else begin m_ga = 1; m_addr = int'(addr_a); end
                m_ptr_b = !m_ptr_b;
            end else if (req_a) begin
                m_ga = 1; m_addr = int'(addr_a);
            end else if (req_b) begin
                m_gb = 1; m_addr = int'(addr_b);
            end
        end
    endtask

    always @(negedge clock) begin
        if (m_valid) begin
            chk("start_policy", start_policy, int'(t == launch_t));
            chk("round_done", round_done, int'(t == done_t));
            chk("busy", busy, m_busy);
            chk("epsilon", epsilon, m_eps);
            chk("nexthop", nexthop, m_nh);
            chk("round_count", round_count, m_rounds);
            chk("timeout_flag", timeout_flag, m_to);
            chk("grant_a", grant_a, m_ga);
            chk("grant_b", grant_b, m_gb);
            chk("mem_addr", mem_addr, m_addr);
        end
        if (start_policy) begin
            sp_count++;
            eps_log.push_back(int'(epsilon));
        end
        if (round_done) begin
            rd_count++;
            rd_t = t;
        end
        model_step();
        t++;
    end

    // Policy engine stand-in: answers eng_delay cycles after each launch (never if negative).
    int eng_delay = -1;
    int eng_vals[$];
    initial begin : engine
        int launch_at;
        launch_at = -1;
        done_policy = 1'b0;
        nexthop_in = '0;
        forever begin
            @(posedge clock); #1;
            done_policy = 1'b0;
            if (start_policy && eng_delay >= 0) launch_at = t;
            else if (launch_at >= 0 && t == launch_at + eng_delay) begin
                done_policy = 1'b1;
                nexthop_in = (eng_vals.size() > 0) ? 16'(eng_vals.pop_front()) : 16'd0;
                launch_at = -1;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clock); #1; end
    endtask

    task automatic do_reset();
        nrst = 1'b0; step(2); nrst = 1'b1; step(1);
    endtask

    task automatic run_batch(input int limit, input int budget, output int lat);
        int rd0, s;
        rd0 = rd_count;
        start_round = 1'b1; round_limit = 16'(limit); s = t;
        step(1);
        start_round = 1'b0;
        lat = -1;
        for (int i = 0; i < budget && rd_count == rd0; i++) step(1);
        if (rd_count == rd0) chk("round_done_wait_expired", 0, 1);
        else lat = rd_t - s;
    endtask

    initial begin : watchdog_limit
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin : main
        int lat, sp0, rd0;
        nrst = 1'b0; start_round = 1'b0; round_limit = '0;
        epsilon_init = 16'd10; epsilon_step = 16'd4;
        req_a = 1'b0; req_b = 1'b0; addr_a = '0; addr_b = '0;
        step(3); nrst = 1'b1; step(2);
        chk("reset_nexthop", nexthop, 100);
        chk("reset_epsilon", epsilon, 10);
        chk("reset_busy", busy, 0);

        // Three rounds, engine answers 7, 8, 9 after 5 cycles each.
        eng_vals = '{7, 8, 9}; eng_delay = 5;
        sp0 = sp_count; rd0 = rd_count; eps_log.delete();
        run_batch(3, 100, lat);
        step(2);
        chk("b3_latency", lat, 22);
        chk("b3_launches", sp_count - sp0, 3);
        chk("b3_round_dones", rd_count - rd0, 1);
        chk("b3_eps_log_size", eps_log.size(), 3);
        if (eps_log.size() == 3) begin
            chk("b3_eps_round2", eps_log[1], 6);
            chk("b3_eps_round3", eps_log[2], 2);
        end
        chk("b3_epsilon_final", epsilon, 0);
        chk("b3_nexthop", nexthop, 9);
        chk("b3_round_count", round_count, 3);
        chk("b3_busy_clear", busy, 0);

        // Engine silent: watchdog expires after 64 WAIT cycles.
        eng_delay = -1;
        run_batch(1, 200, lat);
        step(2);
        chk("to_latency", lat, 67);
        chk("to_nexthop", nexthop, 100);
        chk("to_flag", timeout_flag, 1);

        // Answer lands on the last watchdog cycle and must win.
        do_reset();
        eng_vals = '{12}; eng_delay = 64;
        run_batch(1, 200, lat);
        step(2);
        chk("edge_latency", lat, 67);
        chk("edge_nexthop", nexthop, 12);
        chk("edge_flag", timeout_flag, 0);

        // Zero-round batch.
        sp0 = sp_count;
        run_batch(0, 10, lat);
        step(2);
        chk("zero_latency", lat, 1);
        chk("zero_launches", sp_count - sp0, 0);
        chk("zero_epsilon", epsilon, 6);
        chk("zero_round_count", round_count, 0);

        // Contending requesters alternate A, B, A, ...
        addr_a = 16'h0668; addr_b = 16'h068C; req_a = 1'b1; req_b = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step(1);
            chk("arb_grant_a", grant_a, (i % 2 == 0) ? 1 : 0);
            chk("arb_grant_b", grant_b, (i % 2 == 0) ? 0 : 1);
            chk("arb_mem_addr", mem_addr, (i % 2 == 0) ? 'h668 : 'h68C);
        end
        req_a = 1'b0; req_b = 1'b0;
        step(1);
        chk("arb_idle_grants", int'(grant_a) + int'(grant_b), 0);
        chk("arb_idle_hold", mem_addr, 'h68C);
        req_a = 1'b1;
        step(1);
        req_a = 1'b0;
        chk("arb_single_a", mem_addr, 'h668);

        // Reset mid-WAIT aborts the batch; the next one runs cleanly.
        eng_delay = -1; rd0 = rd_count;
        start_round = 1'b1; round_limit = 16'd1;
        step(1);
        start_round = 1'b0;
        step(10);
        nrst = 1'b0; step(1); nrst = 1'b1;
        step(3);
        chk("abort_busy", busy, 0);
        chk("abort_no_done", rd_count - rd0, 0);
        eng_vals = '{5}; eng_delay = 3;
        run_batch(1, 50, lat);
        step(2);
        chk("after_abort_latency", lat, 6);
        chk("after_abort_dones", rd_count - rd0, 1);
        chk("after_abort_nexthop", nexthop, 5);
        chk("after_abort_rounds", round_count, 1);
        chk("after_abort_epsilon", epsilon, 6);

        step(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/policy_scheduler.md
POLICY_SCHEDULER -- requirements
Module: policy_scheduler

Interface
REQ-001 clock  in  1  system clock; all state changes on rising edge.
REQ-002 nrst  in  1  reset, synchronous, active-low.
REQ-003 start_round  in  1  batch start pulse; sampled only in IDLE.
REQ-004 round_limit  in  16  rounds per batch; sampled when start_round is accepted.
REQ-005 epsilon_init  in  16  epsilon value loaded at reset.
REQ-006 epsilon_step  in  16  per-round epsilon decrement.
REQ-007 done_policy  in  1  policy engine completion; level or pulse accepted.
REQ-008 nexthop_in  in  16  policy engine result; valid when done_policy=1.
REQ-009 req_a, req_b  in  1 each  memory read requests (A = policy engine, B = table updater).
REQ-010 addr_a, addr_b  in  16 each  requested addresses.
REQ-011 start_policy  out  1  one-cycle launch pulse to the policy engine.
REQ-012 epsilon  out  16  current epsilon, driven to the policy engine.
REQ-013 nexthop  out  16  last latched next hop; 100 encodes "none".
REQ-014 round_count  out  16  completed rounds in the current batch.
REQ-015 busy, round_done, timeout_flag  out  1 each  busy while a batch is active; round_done is a one-cycle end-of-batch pulse; timeout_flag is sticky.
REQ-016 mem_addr  out  16  registered address of the granted requester.
REQ-017 grant_a, grant_b  out  1 each  one-cycle registered grants; never both high.

Function
REQ-018 The FSM SHALL have states IDLE, LAUNCH, WAIT, DECAY and DONE; any other encoding SHALL go to IDLE.
REQ-019 IDLE, start_round=1, round_limit!=0: SHALL clear round_count, set busy, go to LAUNCH.
REQ-020 IDLE, start_round=1, round_limit=0: SHALL go to DONE with no launch; round_count stays 0.
REQ-021 LAUNCH: start_policy SHALL be 1 for exactly one cycle; the watchdog SHALL clear to 0; next state is WAIT.
REQ-022 WAIT with done_policy=1: SHALL latch nexthop_in into nexthop and go to DECAY.
REQ-023 WAIT with no done_policy: the watchdog SHALL increment each cycle.
- At watchdog value 63 with done_policy still 0: nexthop<=100, timeout_flag<=1, go to DECAY.
- done_policy and watchdog=63 in the same cycle: done_policy wins.
REQ-024 DECAY: epsilon SHALL be set to 0 if epsilon<epsilon_step, else epsilon-epsilon_step (unsigned, no wrap).
- round_count SHALL increment.
- If the new round_count equals the latched round_limit, go to DONE; otherwise go to LAUNCH.
REQ-025 DONE: round_done=1 for one cycle, busy SHALL clear, next state is IDLE.
REQ-026 Latency: LAUNCH-to-LAUNCH SHALL be (cycles in WAIT)+2.
REQ-027 start_round while busy SHALL be ignored.
REQ-028 done_policy seen in any state other than WAIT SHALL be ignored.
REQ-029 Arbiter, per cycle:
- Exactly one request: grant it on the next edge and load its address into mem_addr.
- Both requesting: grant the side named by the priority pointer; the pointer then flips to the other side.
- No request: grants 0, mem_addr holds.
REQ-030 A continuously requesting pair SHALL alternate grants A,B,A,B...; the arbiter runs independently of the FSM.

Reset
REQ-031 nrst=0 SHALL force:
- state IDLE, start_policy=0, busy=0, round_done=0, timeout_flag=0.
- nexthop=100, round_count=0, epsilon=epsilon_init, watchdog=0.
- mem_addr=0, grant_a=0, grant_b=0, priority pointer=A.
REQ-032 Reset asserted mid-batch SHALL abort it; no round_done is produced.

Structure
REQ-033 A shared package SHALL hold: the word width 16, the nexthop "none" value 100, watchdog limit 63, and the FSM state encoding.
REQ-034 The arbiter SHALL be the sub-module mem_rr_arbiter, instantiated once.

Verification
REQ-035 eps_init=10, step=4, limit=3, engine answers 5 cycles after each launch with 7, 8, 9: three start_policy pulses; epsilon 6, 2, 0; nexthop=9; round_count=3; one round_done.
REQ-036 limit=0: round_done one cycle after start_round; no start_policy; epsilon unchanged.
REQ-037 Engine never answers, limit=1: after 64 WAIT cycles nexthop=100, timeout_flag=1, round_done.
REQ-038 done_policy exactly at watchdog=63 with nexthop_in=12: nexthop=12 and timeout_flag=0.
REQ-039 req_a and req_b held high, addr_a=0x668, addr_b=0x68C: grants alternate starting with A; mem_addr alternates 0x668, 0x68C.
REQ-040 nrst=0 during WAIT, then start_round with limit=1: clean single round; the earlier batch produces no round_done.
